// File: rtl/dual_dac_spi.sv
// Serialises a (ch0, ch1) sample pair into two SPI mode-0 words {ch, 3'b111, data}
// for a dual-channel DAC, separated by a chip-select gap.
module dual_dac_spi #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             _clk,
  input  logic             _rst,
  input  logic             _en,
  input  logic [WIDTH-1:0] _din1,
  input  logic [WIDTH-1:0] _din2,
  input  logic             _valid,
  output logic             _ready,
  output logic             _sclk,
  output logic             _mosi,
  output logic             _cs_n,
  output logic             _busy,
  output logic             _frame_done
);

  localparam int W  = WIDTH + 4;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(W - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic             word_sel;
  logic [W-1:0]     shreg;
  logic [WIDTH-1:0] din2_q;
  logic             accept;
  logic             phase_end;

  assign accept    = _valid & _ready & _en;
  assign phase_end = (state == GAP) ? (cnt == GAP_LAST) : (cnt == HALF_LAST);

  always_ff @(posedge _clk) begin
    if (_rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept)    state_nx = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
      SHIFT_HI: if (phase_end) begin
        if (bit_idx != '0)  state_nx = SHIFT_LO;
        else if (!word_sel) state_nx = GAP;
        else                state_nx = DONE;
      end
      GAP:      if (phase_end) state_nx = SHIFT_LO;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Phase counter restarts on every state change, so each state's dwell is self-timed.
  always_ff @(posedge _clk) begin
    if (_rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      word_sel <= 1'b0;
      shreg    <= '0;
      din2_q   <= '0;
    end else begin
      if (state_nx != state || state == IDLE || state == DONE) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;

      if (state == IDLE && accept) begin
        shreg    <= {1'b0, 3'b111, _din1};
        din2_q   <= _din2;
        bit_idx  <= IDX_TOP;
        word_sel <= 1'b0;
      end else if (state == SHIFT_HI && phase_end && bit_idx != '0) begin
        shreg   <= {shreg[W-2:0], 1'b0};
        bit_idx <= bit_idx - 1'b1;
      end else if (state == GAP && phase_end) begin
        shreg    <= {1'b1, 3'b111, din2_q};
        bit_idx  <= IDX_TOP;
        word_sel <= 1'b1;
      end
    end
  end

  // Shift only happens at the end of SHIFT_HI, so MOSI changes while SCLK is low.
  always_comb begin
    _ready      = 1'b0;
    _sclk       = 1'b0;
    _mosi       = 1'b0;
    _cs_n       = 1'b1;
    _busy       = 1'b1;
    _frame_done = 1'b0;
    case (state)
      IDLE: begin
        _ready = 1'b1;
        _busy  = 1'b0;
      end
      SHIFT_LO: begin
        _cs_n = 1'b0;
        _mosi = shreg[W-1];
      end
      SHIFT_HI: begin
        _cs_n = 1'b0;
        _sclk = 1'b1;
        _mosi = shreg[W-1];
      end
      DONE:    _frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dual_dac_spi.sv
// Directed bench for dual_dac_spi: three instances (CLK_DIV 2, 1, 5) on shared inputs,
// a cycle-exact per-frame model, and an SPI word monitor on the CLK_DIV=2 instance.
module tb_dual_dac_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic [7:0] din2 = 8'h00;
  logic [2:0] ready, sclk, mosi, cs_n, busy, fd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dual_dac_spi #(.WIDTH(8), .CLK_DIV(2)) u0 (
    ._clk(clk), ._rst(rst), ._en(en), ._din1(din1), ._din2(din2), ._valid(valid),
    ._ready(ready[0]), ._sclk(sclk[0]), ._mosi(mosi[0]), ._cs_n(cs_n[0]),
    ._busy(busy[0]), ._frame_done(fd[0]));
  dual_dac_spi #(.WIDTH(8), .CLK_DIV(1)) u1 (
    ._clk(clk), ._rst(rst), ._en(en), ._din1(din1), ._din2(din2), ._valid(valid),
    ._ready(ready[1]), ._sclk(sclk[1]), ._mosi(mosi[1]), ._cs_n(cs_n[1]),
    ._busy(busy[1]), ._frame_done(fd[1]));
  dual_dac_spi #(.WIDTH(8), .CLK_DIV(5)) u2 (
    ._clk(clk), ._rst(rst), ._en(en), ._din1(din1), ._din2(din2), ._valid(valid),
    ._ready(ready[2]), ._sclk(sclk[2]), ._mosi(mosi[2]), ._cs_n(cs_n[2]),
    ._busy(busy[2]), ._frame_done(fd[2]));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // SPI monitor (instance 0) plus MOSI/SCLK protocol checks on all instances.
  logic [11:0] wq[$];
  int          bq[$];
  logic [11:0] mon_sh = '0;
  int          mon_bits = 0;
  logic [2:0]  sclk_q = '0, mosi_q = '0;
  logic        cs_q = 1'b1;

  initial forever begin
    @(negedge clk);
    if (sclk[0] && !sclk_q[0] && !cs_n[0]) begin
      mon_sh   = {mon_sh[10:0], mosi[0]};
      mon_bits = mon_bits + 1;
    end
    if (cs_n[0] && !cs_q) begin
      wq.push_back(mon_sh);
      bq.push_back(mon_bits);
      mon_bits = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (sclk[i] && sclk_q[i]) check("mosi_stable_sclk_high", {31'd0, mosi[i]}, {31'd0, mosi_q[i]});
      if (sclk[i]) check("sclk_only_with_cs", {31'd0, cs_n[i]}, 32'd0);
    end
    sclk_q = sclk;
    mosi_q = mosi;
    cs_q   = cs_n[0];
  end

  typedef struct {
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [11:0] w0;
    logic [11:0] w1;
  } vec_t;

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    din1 = a; din2 = b; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Called right after the accept edge; cycle k is the k-th clock period after it.
  task automatic frame_check(input int i, input int d, input logic [11:0] w0, input logic [11:0] w1);
    int wd, len, p;
    logic sh, e_sclk, e_mosi;
    logic [11:0] w;
    wd  = 12 * d;
    len = 4 * wd + 2 * d + 1;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      sh = 1'b0; p = 0; w = w0;
      if (k >= 1 && k <= 2 * wd) begin
        sh = 1'b1; p = k - 1; w = w0;
      end else if (k >= 2 * wd + 2 * d + 1 && k <= 4 * wd + 2 * d) begin
        sh = 1'b1; p = k - 1 - 2 * wd - 2 * d; w = w1;
      end
      e_sclk = sh ? (((p / d) % 2) == 1) : 1'b0;
      e_mosi = sh ? w[11 - p / (2 * d)] : 1'b0;
      check("cs_n",       {31'd0, cs_n[i]},  {31'd0, !sh});
      check("sclk",       {31'd0, sclk[i]},  {31'd0, e_sclk});
      check("mosi",       {31'd0, mosi[i]},  {31'd0, e_mosi});
      check("frame_done", {31'd0, fd[i]},    {31'd0, (k == len)});
      check("ready",      {31'd0, ready[i]}, {31'd0, (k == len + 1)});
      check("busy",       {31'd0, busy[i]},  {31'd0, (k <= len)});
    end
  endtask

  task automatic wait_fd(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd[0] && n < max);
    check("frame_done_timeout", {31'd0, fd[0]}, 32'd1);
  endtask

  task automatic check_words(input logic [11:0] a, input logic [11:0] b);
    check("word_count", wq.size(), 2);
    if (wq.size() >= 2) begin
      check("word0", {20'd0, wq[0]}, {20'd0, a});
      check("word1", {20'd0, wq[1]}, {20'd0, b});
      check("word0_bits", bq[0], 12);
      check("word1_bits", bq[1], 12);
    end
  endtask

  vec_t vecs[4];
  int   hi, nfd;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 12'h7A5, 12'hF3C};
    vecs[1] = '{8'h00, 8'hFF, 12'h700, 12'hFFF};
    vecs[2] = '{8'h80, 8'h01, 12'h780, 12'hF01};
    vecs[3] = '{8'hFF, 8'h00, 12'h7FF, 12'hF00};

    // Reset held 3 cycles, then idle.
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready[0]}, 32'd1);
      check("idle_cs_n",  {31'd0, cs_n[0]},  32'd1);
      check("idle_sclk",  {31'd0, sclk[0]},  32'd0);
      check("idle_busy",  {31'd0, busy[0]},  32'd0);
      check("idle_fd",    {31'd0, fd[0]},    32'd0);
      if (k == 2) rst = 1'b0;
    end

    // Single frames from the vector table.
    en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      wq.delete(); bq.delete();
      send(vecs[v].d1, vecs[v].d2);
      frame_check(0, 2, vecs[v].w0, vecs[v].w1);
      check_words(vecs[v].w0, vecs[v].w1);
    end

    // Enable gating, en dropped mid-frame, and input changes after accept.
    en = 1'b0;
    @(negedge clk);
    din1 = 8'h11; din2 = 8'h22; valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("en_low_ready", {31'd0, ready[0]}, 32'd1);
      check("en_low_busy",  {31'd0, busy[0]},  32'd0);
    end
    wq.delete(); bq.delete();
    en = 1'b1;
    @(negedge clk);
    check("en_accept_busy", {31'd0, busy[0]}, 32'd1);
    valid = 1'b0; en = 1'b0;
    repeat (10) @(negedge clk);
    din1 = 8'hFF; din2 = 8'hFF;
    wait_fd(200);
    @(negedge clk);
    check_words(12'h711, 12'hF22);
    en = 1'b1;

    // Back-to-back with valid held.
    wq.delete(); bq.delete();
    din1 = 8'h00; din2 = 8'hFF; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din1 = 8'h80; din2 = 8'h01;
    wait_fd(200);
    hi = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cs_n[0]) hi++;
      else break;
    end
    valid = 1'b0;
    check("interframe_cs_high", hi, 2);
    wait_fd(200);
    @(negedge clk);
    check("b2b_count", wq.size(), 4);
    if (wq.size() >= 4) begin
      check("b2b_w0", {20'd0, wq[0]}, 32'h700);
      check("b2b_w1", {20'd0, wq[1]}, 32'hFFF);
      check("b2b_w2", {20'd0, wq[2]}, 32'h780);
      check("b2b_w3", {20'd0, wq[3]}, 32'hF01);
    end

    // Reset mid-word at cycle 20 of a frame.
    send(8'h5A, 8'hC3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cs_n",  {31'd0, cs_n[0]},  32'd1);
    check("rst_sclk",  {31'd0, sclk[0]},  32'd0);
    check("rst_ready", {31'd0, ready[0]}, 32'd1);
    check("rst_busy",  {31'd0, busy[0]},  32'd0);
    check("rst_fd",    {31'd0, fd[0]},    32'd0);
    rst = 1'b0;
    nfd = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (fd[0]) nfd++;
    end
    check("no_fd_after_rst", nfd, 0);
    wq.delete(); bq.delete();
    send(8'hFF, 8'h00);
    frame_check(0, 2, 12'h7FF, 12'hF00);
    check_words(12'h7FF, 12'hF00);

    // CLK_DIV sweep on the other two instances.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'hA5, 8'h3C);
    fork
      frame_check(1, 1, 12'h7A5, 12'hF3C);
      frame_check(2, 5, 12'h7A5, 12'hF3C);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_dac_spi.md
Name: dual_dac_spi

Overview:
- Downstream output stage of the sine generator.
- Takes the paired samples `_dout1` and `_dout2` (the reference and phase-shifted channels) and serialises them into two SPI-mode-0 write words for a dual-channel DAC.
- Uses a valid/ready handshake so the generator side can hold a sample pair until the serialiser is free.
- Each accepted pair produces one frame: a channel-0 word, an inter-word gap, then a channel-1 word.

Parameters:
- WIDTH, 8, sample width in bits; matches the sine generator data width.
- CLK_DIV, 2, `_clk` cycles per `_sclk` half-period; legal range ≥ 1.

Ports:
- `_clk` input 1: system clock; all logic rises on its edge.
- `_rst` input 1: synchronous, active-high reset.
- `_en` input 1: enable; gates acceptance of new sample pairs only.
- `_din1` input WIDTH: channel-0 sample, from the generator's `_dout1`.
- `_din2` input WIDTH: channel-1 sample, from the generator's `_dout2`.
- `_valid` input 1: upstream asserts when `_din1`/`_din2` hold a pair.
- `_ready` output 1: high when a pair can be accepted.
- `_sclk` output 1: serial clock to the DAC; idles low.
- `_mosi` output 1: serial data, MSB first.
- `_cs_n` output 1: active-low chip select, one assertion per word.
- `_busy` output 1: high while a frame is in flight (any state except IDLE).
- `_frame_done` output 1: one-cycle pulse after the second word completes.

Behaviour:
- Reset values:
  - `_ready` = 1, `_sclk` = 0, `_mosi` = 0, `_cs_n` = 1, `_busy` = 0, `_frame_done` = 0.
  - Shift register and counters cleared; FSM in IDLE.
- Accept rule:
  - Accept occurs on a rising edge where `_valid` & `_ready` & `_en` = 1.
  - `_din1`/`_din2` are captured into internal registers on that edge.
  - `_ready` drops to 0 on the same edge.
  - `_valid` while `_ready` = 0 or `_en` = 0 is ignored; nothing is queued.
- Word format, WIDTH+4 bits, MSB first:
  - Bit layout is {ch, 3'b111, data}.
  - The channel-0 word uses ch = 0, data = `_din1`.
  - The channel-1 word uses ch = 1, data = `_din2`.
  - Example at WIDTH = 8: `_din1` = 0xA5 → word 0x7A5; `_din2` = 0x3C → word 0xF3C.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, GAP, DONE.
  - IDLE → SHIFT_LO on accept: word 0 loaded, bit index = WIDTH+3, `_cs_n` goes low the next cycle.
  - SHIFT_LO, lasting CLK_DIV cycles:
    - `_sclk` = 0; `_mosi` = current bit, stable for the whole state.
    - Then → SHIFT_HI.
  - SHIFT_HI, lasting CLK_DIV cycles:
    - `_sclk` = 1; `_mosi` held.
    - At the end, if bit index > 0: decrement the index and → SHIFT_LO.
    - At the end, if bit index = 0 and the word is word 0: → GAP.
    - At the end, if bit index = 0 and the word is word 1: → DONE.
  - GAP, lasting 2*CLK_DIV cycles:
    - `_cs_n` = 1, `_sclk` = 0, `_mosi` = 0.
    - Then word 1 is loaded and → SHIFT_LO.
  - DONE, lasting 1 cycle:
    - `_frame_done` = 1, `_cs_n` = 1, `_ready` = 0.
    - Then → IDLE, where `_ready` = 1.
- Cycle accounting (accept edge = cycle 0, W = WIDTH+4, D = CLK_DIV):
  - `_cs_n` low for cycles 1 .. 2WD.
  - `_cs_n` high for the gap, 2D cycles.
  - `_cs_n` low for the next 2WD cycles.
  - `_frame_done` in cycle 4WD+2D+1.
  - `_ready` = 1 from cycle 4WD+2D+2.
  - At WIDTH = 8, D = 2: `_cs_n` low 1..48, gap 49..52, low 53..100, `_frame_done` at 101, `_ready` at 102.
- Back-to-back frames: an accept in the first IDLE cycle after DONE is legal. Minimum inter-frame `_cs_n`-high time is 2 cycles (DONE + IDLE).
- `_en` dropping mid-frame: has no effect; the frame completes and only further accepts are blocked.
- Data stability: captured data is unaffected by `_din1`/`_din2` changes after accept.
- Reset mid-frame: on the next edge all outputs take their reset values (`_cs_n` = 1 immediately) and the partial frame is discarded. No `_frame_done` is issued.
- `_rst` has priority over accept on the same edge.
- `_mosi` must never change while `_sclk` = 1.
- `_sclk` toggles only while `_cs_n` = 0.

Test Plan:
- Reset then idle: assert `_rst` 3 cycles, `_valid` = 0 → `_ready` = 1, `_cs_n` = 1, `_sclk` = 0, `_busy` = 0 throughout.
- Single frame, CLK_DIV = 2: `_din1` = 0xA5, `_din2` = 0x3C, one-cycle `_valid` → bench SPI monitor captures 0x7A5 then 0xF3C.
  - 12 rising `_sclk` edges per word.
  - `_cs_n` low at cycles 1..48 and 53..100.
  - `_frame_done` at cycle 101, `_ready` at cycle 102.
- Handshake/enable: `_valid` held high with `_en` = 0 → no accept for 20 cycles. Raise `_en` → accept on the next edge.
  - Changing `_din1` to 0xFF mid-frame does not alter the captured 0x7xx word.
- Back-to-back: `_valid` held continuously with pairs (0x00, 0xFF) then (0x80, 0x01) → words 0x700, 0xFFF, 0x780, 0xF01.
  - Exactly 2 cycles of `_cs_n` high between frames.
- Reset mid-word: assert `_rst` at cycle 20 of a frame → next cycle `_cs_n` = 1, `_sclk` = 0, `_ready` = 1, no `_frame_done`.
  - A new pair then transmits correctly.
- Parameter sweep: CLK_DIV = 1 and CLK_DIV = 5 with WIDTH = 8 → `_sclk` half-period equals CLK_DIV cycles, and frame length matches 4WD+2D+1.
  - `_mosi` stable across every high `_sclk` phase (assertion).
